// File: rtl/quad_encoder_gen_pkg.sv
// Shared motor-encoder constants: FSM encodings, Gray next-phase tables, default widths.
// Also imported by the quadrature decoder so both ends agree on the phase order.
package quad_encoder_gen_pkg;

  localparam int PERIOD_W_DEF = 16;
  localparam int COUNT_W_DEF  = 16;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } enc_state_e;

  // Phase as {A,B}.
  typedef logic [1:0] ab_t;

  // Next phase indexed by the current {A,B}.
  // Forward 00->10->11->01->00, reverse 00->01->11->10->00.
  localparam ab_t GRAY_FWD [4] = '{2'b10, 2'b00, 2'b11, 2'b01};
  localparam ab_t GRAY_REV [4] = '{2'b01, 2'b11, 2'b00, 2'b10};

  function automatic ab_t gray_next(input ab_t cur, input logic fwd);
    return fwd ? GRAY_FWD[cur] : GRAY_REV[cur];
  endfunction

endpackage

// File: rtl/quad_encoder_gen_if.sv
// Control and encoder-output bundle of the quadrature encoder generator.
// The master drives the run request; the slave (the generator) drives A/B and status.
interface quad_encoder_gen_if
  import quad_encoder_gen_pkg::*;
#(
  parameter int PERIOD_W = PERIOD_W_DEF,
  parameter int COUNT_W  = COUNT_W_DEF
);

  logic                start;
  logic                abort;
  logic                dir;
  logic [PERIOD_W-1:0] step_ticks;
  logic [COUNT_W-1:0]  cycles;
  logic                A;
  logic                B;
  logic                busy;
  logic                done;
  logic [COUNT_W-1:0]  pos;

  modport master (
    output start, abort, dir, step_ticks, cycles,
    input  A, B, busy, done, pos
  );

  modport slave (
    input  start, abort, dir, step_ticks, cycles,
    output A, B, busy, done, pos
  );

endinterface

// File: rtl/quad_encoder_gen_step_timer.sv
// Loadable edge-spacing down-counter. o_expire is high during the last cycle of a
// loaded interval, so a reload on o_expire yields an event every load_val cycles.
module step_timer #(
  parameter int PERIOD_W = 16
) (
  input  logic                clk_sys,
  input  logic                rst_n,
  input  logic                i_reload,
  input  logic [PERIOD_W-1:0] i_load_val,
  output logic                o_expire
);

  logic [PERIOD_W-1:0] r_cnt;

  // NOTE: state is updated only with non-blocking assignments and the reset is
  // sampled on the clock edge, so every register here is a plain synchronous flop.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_reload) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - PERIOD_W'(1);
    end
  end

  assign o_expire = (r_cnt == PERIOD_W'(1));

endmodule

// File: rtl/quad_encoder_gen.sv
// Quadrature encoder generator: emits 4*cycles Gray-coded A/B edges spaced step_ticks
// apart, tracking a signed edge position. Phase and position persist across runs.
module quad_encoder_gen
  import quad_encoder_gen_pkg::*;
#(
  parameter int PERIOD_W = PERIOD_W_DEF,
  parameter int COUNT_W  = COUNT_W_DEF
) (
  input logic               clk_sys,
  input logic               rst_n,
  quad_encoder_gen_if.slave bus
);

  localparam int BUDGET_W = COUNT_W + 2;

  enc_state_e          r_state;
  enc_state_e          w_state_nxt;
  logic                r_dir;
  logic [PERIOD_W-1:0] r_step;
  logic [BUDGET_W-1:0] r_budget;
  ab_t                 r_ab;
  logic [COUNT_W-1:0]  r_pos;
  logic                r_done;

  logic                w_go;
  logic                w_edge;
  logic                w_last;
  logic                w_done_nxt;
  logic                w_tmr_reload;
  logic [PERIOD_W-1:0] w_tmr_val;
  logic [PERIOD_W-1:0] w_step_eff;
  logic                w_expire;

  assign w_step_eff = (bus.step_ticks == '0) ? PERIOD_W'(1) : bus.step_ticks;

  step_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_step_timer (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .i_reload   (w_tmr_reload),
    .i_load_val (w_tmr_val),
    .o_expire   (w_expire)
  );

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every signal assigned in this block gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt  = r_state;
    w_go         = 1'b0;
    w_edge       = 1'b0;
    w_last       = 1'b0;
    w_done_nxt   = 1'b0;
    w_tmr_reload = 1'b0;
    w_tmr_val    = '0;
    unique case (r_state)
      ST_IDLE: begin
        // Hold the timer cleared while idle; arm it with the spacing on start.
        w_tmr_reload = 1'b1;
        if (bus.start && !bus.abort) begin
          w_go        = 1'b1;
          w_state_nxt = ST_RUN;
          w_tmr_val   = w_step_eff;
        end
      end
      ST_RUN: begin
        w_edge = w_expire && (r_budget != '0);
        w_last = (r_budget == '0) || (w_edge && (r_budget == BUDGET_W'(1)));
        if (bus.abort || w_last) begin
          // A coincident edge is still emitted; abort only suppresses done.
          w_state_nxt  = ST_IDLE;
          w_done_nxt   = !bus.abort;
          w_tmr_reload = 1'b1;
        end else if (w_edge) begin
          w_tmr_reload = 1'b1;
          w_tmr_val    = r_step;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      r_dir    <= 1'b0;
      r_step   <= '0;
      r_budget <= '0;
      r_ab     <= 2'b00;
      r_pos    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
      if (w_go) begin
        r_dir    <= bus.dir;
        r_step   <= w_step_eff;
        r_budget <= {bus.cycles, 2'b00};
      end
      if (w_edge) begin
        r_ab     <= gray_next(r_ab, r_dir);
        r_pos    <= r_dir ? (r_pos + COUNT_W'(1)) : (r_pos - COUNT_W'(1));
        r_budget <= r_budget - BUDGET_W'(1);
      end
    end
  end

  assign bus.A    = r_ab[1];
  assign bus.B    = r_ab[0];
  assign bus.busy = (r_state == ST_RUN);
  assign bus.done = r_done;
  assign bus.pos  = r_pos;

endmodule

// File: doc/quad_encoder_gen.md
# quad_encoder_gen

Quadrature encoder generator: the transmit side of the motor's A/B encoder interface. Given a direction, an edge spacing in `clk_sys` cycles, and a number of full quadrature cycles, it drives Gray-coded A/B outputs exactly as a physical encoder would. It feeds the quadrature decoder / pulse-measurement path, either as a closed-loop stimulus source in the test bench or as an on-board encoder emulator for motor-less bring-up.

## Interface
Parameters:
- `PERIOD_W`, 16: width of `step_ticks`.
- `COUNT_W`, 16: width of `cycles` and of the edge counters.

Ports:
- `clk_sys`, in, 1: single system clock. All logic is on its rising edge.
- `rst_n`, in, 1: reset, synchronous and active-low.
- `start`, in, 1: single-cycle request to begin a run. Sampled only in IDLE.
- `abort`, in, 1: stops a run in progress.
- `dir`, in, 1: direction. 1 = forward (A leads B); 0 = reverse (B leads A).
- `step_ticks`, in, PERIOD_W: `clk_sys` cycles between successive A/B edges.
- `cycles`, in, COUNT_W: number of full quadrature cycles to emit (4 edges each).
- `A`, out, 1: encoder channel A (registered).
- `B`, out, 1: encoder channel B (registered).
- `busy`, out, 1: high while a run is active.
- `done`, out, 1: one-cycle pulse when a run completes normally.
- `pos`, out, COUNT_W: signed edge position. +1 per forward edge, −1 per reverse edge, wraps modulo 2^COUNT_W.

## Operation
- FSM states:
  - IDLE. `start` moves to RUN. On entry to RUN, latch `dir`, `step_ticks` (a value of 0 is treated as 1) and the edge budget `4*cycles`.
  - RUN. An edge timer counts `step_ticks` cycles. On expiry, advance the A/B phase one step, update `pos`, decrement the budget and reload the timer.
    - When the budget reaches 0, return to IDLE and pulse `done`.
    - `abort` returns to IDLE next cycle: no `done`, A/B/`pos` hold their current values.
- Phase sequence as {A,B}:
  - Forward: 00→10→11→01→00.
  - Reverse: 00→01→11→10→00.
  - Exactly one output toggles per edge.
- Phase is NOT reset between runs. A new run continues from the current {A,B}, so runs of opposite direction chain glitch-free.
- `cycles`=0: the run enters RUN, emits no edge, and pulses `done` the next cycle.
- Inputs changing during RUN are ignored. Only the values latched at start apply.
- `start` during RUN is ignored.
- `start` and `abort` in the same IDLE cycle: abort wins, no run starts.
- `abort` in the same cycle as the final edge: the edge is emitted and `done` does not pulse.
- Reset values: A=0, B=0, `busy`=0, `done`=0, `pos`=0, FSM=IDLE, timer and budget=0. Reset mid-run abandons the run immediately.

## Timing
- `start` sampled at edge k:
  - `busy`=1 from edge k.
  - A/B change at edges k+S, k+2S, …, k+4N·S, where S = effective `step_ticks` and N = `cycles`.
- On the final edge (k+4N·S), `busy` falls and `done`=1 for exactly one cycle, registered on the same edge as the last A/B change.
- Back-to-back runs: a `start` sampled at edge k+4N·S+1 (the first IDLE cycle) is accepted, with no dead time beyond that cycle.
- Full quadrature period is 4·S cycles. The minimum S=1 gives an A/B toggle rate of `clk_sys`/4 per channel.
- `pos` updates on the same edge as A/B. `pos` is not reset by `start`; only `rst_n` clears it.

## Structure
- Shared motor constants, in the package/include also used by the decoder:
  - FSM state encodings (IDLE, RUN).
  - Forward and reverse Gray next-state tables.
  - Default PERIOD_W and COUNT_W.
- Sub-module `step_timer`: loadable down-counter with a `reload` input and a one-cycle `expire` output, PERIOD_W wide. The FSM, phase register and `pos` counter stay in the top module.

## Test plan
- Reset, then `dir`=1, `step_ticks`=3, `cycles`=2, `start` at edge 0:
  - {A,B} = 10@3, 11@6, 01@9, 00@12, 10@15, 11@18, 01@21, 00@24.
  - `done` pulses at 24; `pos`=8; `busy` high edges 0–23.
- From {A,B}=00, `dir`=0, `step_ticks`=0, `cycles`=1: edges every cycle (01,11,10,00), `pos`=−4 (0xFFFC), `done` after 4 cycles.
- Forward run with `cycles`=1, stop mid-way by `abort` at the second edge, then reverse `start` with `cycles`=1:
  - A/B hold 11, no `done` on the abort.
  - The reverse run starts from 11 (next 10) and ends at 11; `pos` goes 2→−2.
- `cycles`=0: `done` one cycle after start, A/B unchanged.
- `start` asserted during RUN has no effect. `start` in the first IDLE cycle after `done` is accepted.
- Simultaneous `start`+`abort` in IDLE: `busy` stays 0.
- Closed loop: connect A/B to the quadrature decoder plus pulse measurement with `step_ticks`=50; the decoded pulse count and period match 4·`cycles` edges at 50-cycle spacing.
